// File: rtl/dmem_pkg.sv
// Shared definitions for the MEM-stage data memory arbiter: widths,
// memory depth, requester port ids and the sequencer state encoding.
package dmem_pkg;

  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 32;
  localparam int MEM_DEPTH = 256;

  localparam logic P_CPU = 1'b0;
  localparam logic P_DBG = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // True when the word address lies below MEM_DEPTH; addresses do not wrap.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
    return a < ADDR_W'(MEM_DEPTH);
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data memory.
// Handshake: a requester raises reqN with weN/addrN/wdataN stable and holds
// them until ackN; ackN is a single-cycle pulse and rdataN/errN are valid
// only while ackN=1. reqN still high in the cycle after ackN is a new
// request. Memory strobes are single-cycle and registered, so they are
// stable across the falling edge on which the memory samples them.
interface dmem_arbiter_if;
  import dmem_pkg::*;

  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              ack0;
  logic [DATA_W-1:0] rdata0;
  logic              err0;

  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              ack1;
  logic [DATA_W-1:0] rdata1;
  logic              err1;

  logic              MemRead;
  logic              MemWrite;
  logic [ADDR_W-1:0] Address;
  logic [DATA_W-1:0] WriteData;
  logic [DATA_W-1:0] ReadData;

  // Requesters and memory side
  modport master (
    output req0, we0, addr0, wdata0,
    input  ack0, rdata0, err0,
    output req1, we1, addr1, wdata1,
    input  ack1, rdata1, err1,
    input  MemRead, MemWrite, Address, WriteData,
    output ReadData
  );

  // Arbiter side
  modport slave (
    input  req0, we0, addr0, wdata0,
    output ack0, rdata0, err0,
    input  req1, we1, addr1, wdata1,
    output ack1, rdata1, err1,
    output MemRead, MemWrite, Address, WriteData,
    input  ReadData
  );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Combinational two-way round-robin grant. A lone request wins outright;
// on a tie the port that did not win last time is chosen.
module rr_arb2
  import dmem_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic gnt_valid,
  output logic gnt_id
);

  // Grant selection
  always_comb begin
    gnt_valid = req0 | req1;
    gnt_id    = P_CPU;
    if (req0 && req1) begin
      gnt_id = ~last_grant;
    end else if (req1) begin
      gnt_id = P_DBG;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter and sequencer for the shared single-port data memory. Each
// transaction runs IDLE (grant) -> ACCESS (strobe) -> RESP (ack), three
// cycles from the sampled request to the ack cycle inclusive.
module dmem_arbiter
  import dmem_pkg::*;
(
  input  logic           Clk,
  input  logic           Rst_n,
  dmem_arbiter_if.slave  bus,
  output state_t         dbg_state
);

  state_t state, next_state;

  logic last_grant;
  logic gnt_valid, gnt_id;
  logic grant_en;

  logic cmd_id;
  logic cmd_we;
  logic cmd_err;

  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_ok;

  assign dbg_state = state;

  rr_arb2 u_rr_arb2 (
    .req0       (bus.req0),
    .req1       (bus.req1),
    .last_grant (last_grant),
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_id)
  );

  // Winner's command fields and range check
  always_comb begin
    sel_we    = bus.we0;
    sel_addr  = bus.addr0;
    sel_wdata = bus.wdata0;
    if (gnt_id == P_DBG) begin
      sel_we    = bus.we1;
      sel_addr  = bus.addr1;
      sel_wdata = bus.wdata1;
    end
    sel_ok = addr_in_range(sel_addr);
  end

  // State register
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and grant enable
  always_comb begin
    next_state = state;
    grant_en   = 1'b0;
    case (state)
      IDLE: begin
        if (gnt_valid) begin
          grant_en   = 1'b1;
          next_state = ACCESS;
        end
      end
      ACCESS:  next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Command latch and registered memory strobes (high only in ACCESS)
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cmd_id        <= P_CPU;
      cmd_we        <= 1'b0;
      cmd_err       <= 1'b0;
      bus.Address   <= '0;
      bus.WriteData <= '0;
      bus.MemRead   <= 1'b0;
      bus.MemWrite  <= 1'b0;
    end else if (grant_en) begin
      cmd_id        <= gnt_id;
      cmd_we        <= sel_we;
      cmd_err       <= ~sel_ok;
      bus.Address   <= sel_addr;
      bus.WriteData <= sel_wdata;
      bus.MemRead   <= ~sel_we & sel_ok;
      bus.MemWrite  <= sel_we & sel_ok;
    end else begin
      bus.MemRead   <= 1'b0;
      bus.MemWrite  <= 1'b0;
    end
  end

  // Response registers: ack pulse in RESP, data captured at ACCESS end
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      bus.ack0   <= 1'b0;
      bus.ack1   <= 1'b0;
      bus.rdata0 <= '0;
      bus.rdata1 <= '0;
      bus.err0   <= 1'b0;
      bus.err1   <= 1'b0;
    end else begin
      bus.ack0 <= (state == ACCESS) && (cmd_id == P_CPU);
      bus.ack1 <= (state == ACCESS) && (cmd_id == P_DBG);
      if (state == ACCESS) begin
        if (cmd_id == P_CPU) begin
          bus.rdata0 <= (cmd_we || cmd_err) ? '0 : bus.ReadData;
          bus.err0   <= cmd_err;
        end else begin
          bus.rdata1 <= (cmd_we || cmd_err) ? '0 : bus.ReadData;
          bus.err1   <= cmd_err;
        end
      end
    end
  end

  // Round-robin history, updated when a transaction completes
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      last_grant <= P_DBG;
    end else if (state == RESP) begin
      last_grant <= cmd_id;
    end
  end

endmodule
